// File: rtl/trap_handler_ctrl_pkg.sv
// rtl/trap_handler_ctrl_pkg.sv - shared constants, types and helpers for the trap handler
package trap_handler_ctrl_pkg;

  localparam int unsigned XLEN_W = 32;

  // Machine trap CSR addresses
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  // Exception / interrupt codes
  localparam logic [3:0] EXC_ILLEGAL_INSTR = 4'd2;
  localparam logic [3:0] IRQ_M_EXT         = 4'd11;

  // Privilege encodings
  localparam logic [1:0] PRIV_M = 2'b11;
  localparam logic [1:0] PRIV_U = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_EXIT,
    ST_REDIRECT
  } state_e;

  typedef struct packed {
    logic              valid;
    logic              irq;
    logic [3:0]        cause;
    logic [XLEN_W-1:0] pc;
    logic [XLEN_W-1:0] tval;
  } trap_req_t;

  // Handler address: BASE, or BASE + 4*code for interrupts in vectored mode
  function automatic logic [XLEN_W-1:0] trap_target(logic [XLEN_W-1:0] mtvec,
                                                   logic irq, logic [3:0] code);
    logic [XLEN_W-1:0] base;
    base = {mtvec[XLEN_W-1:2], 2'b00};
    if (irq && (mtvec[1:0] == 2'b01)) begin
      return base + {{(XLEN_W-6){1'b0}}, code, 2'b00};
    end
    return base;
  endfunction

endpackage

// File: rtl/trap_handler_ctrl_if.sv
// rtl/trap_handler_ctrl_if.sv - trap request, CSR access and redirect signal bundle
interface trap_handler_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  logic            trap_valid;
  logic [3:0]      trap_cause;
  logic [XLEN-1:0] trap_pc;
  logic [XLEN-1:0] trap_tval;
  logic            mret_valid;
  logic            irq_ext;
  logic            csr_we;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;
  logic            busy_o;
  logic            flush_o;
  logic            redirect_valid_o;
  logic [XLEN-1:0] redirect_pc_o;
  logic [1:0]      priv_o;
  logic            mie_o;
  logic            mpie_o;
  logic [1:0]      mpp_o;

  modport master (
    output trap_valid, trap_cause, trap_pc, trap_tval, mret_valid, irq_ext,
    output csr_we, csr_addr, csr_wdata,
    input  csr_rdata, busy_o, flush_o, redirect_valid_o, redirect_pc_o,
    input  priv_o, mie_o, mpie_o, mpp_o
  );

  modport slave (
    input  trap_valid, trap_cause, trap_pc, trap_tval, mret_valid, irq_ext,
    input  csr_we, csr_addr, csr_wdata,
    output csr_rdata, busy_o, flush_o, redirect_valid_o, redirect_pc_o,
    output priv_o, mie_o, mpie_o, mpp_o
  );
endinterface

// File: rtl/trap_csr_file.sv
// rtl/trap_csr_file.sv - machine trap CSR storage, WARL masking and read mux
module trap_csr_file
  import trap_handler_ctrl_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_MTVEC = 32'h0000_0100
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            we_i,
  input  logic [11:0]     addr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] rdata_o,
  input  logic            irq_ext_i,
  input  logic            entry_i,
  input  logic            exit_i,
  input  logic            entry_irq_i,
  input  logic [3:0]      entry_code_i,
  input  logic [XLEN-1:0] entry_pc_i,
  input  logic [XLEN-1:0] entry_tval_i,
  output logic [XLEN-1:0] mtvec_o,
  output logic [XLEN-1:0] mepc_o,
  output logic            meie_o,
  output logic            mie_o,
  output logic            mpie_o,
  output logic [1:0]      mpp_o,
  output logic [1:0]      priv_o
);

  logic            mie_q;
  logic            mpie_q;
  logic [1:0]      mpp_q;
  logic [1:0]      priv_q;
  logic            meie_q;
  logic [XLEN-1:0] mtvec_q;
  logic [XLEN-1:0] mepc_q;
  logic [XLEN-1:0] mcause_q;
  logic [XLEN-1:0] mtval_q;

  logic [1:0]      mpp_wr;
  logic [XLEN-1:0] mtvec_wr;

  // WARL legalisation of software writes: MPP=10 -> 00, mtvec MODE 2/3 -> 0
  always_comb begin
    mpp_wr   = (wdata_i[12:11] == 2'b10) ? PRIV_U : wdata_i[12:11];
    mtvec_wr = {wdata_i[XLEN-1:2], (wdata_i[1] ? 2'b00 : wdata_i[1:0])};
  end

  // CSR state: trap entry/return updates, otherwise software writes
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
      mpp_q    <= PRIV_M;
      priv_q   <= PRIV_M;
      meie_q   <= 1'b0;
      mtvec_q  <= RESET_MTVEC;
      mepc_q   <= '0;
      mcause_q <= '0;
      mtval_q  <= '0;
    end else if (entry_i) begin
      mepc_q   <= {entry_pc_i[XLEN-1:2], 2'b00};
      mcause_q <= {entry_irq_i, {(XLEN-5){1'b0}}, entry_code_i};
      mtval_q  <= entry_irq_i ? '0 : entry_tval_i;
      mpie_q   <= mie_q;
      mie_q    <= 1'b0;
      mpp_q    <= priv_q;
      priv_q   <= PRIV_M;
    end else if (exit_i) begin
      mie_q    <= mpie_q;
      mpie_q   <= 1'b1;
      priv_q   <= mpp_q;
      mpp_q    <= PRIV_U;
    end else if (we_i) begin
      case (addr_i)
        CSR_MSTATUS: begin
          mie_q  <= wdata_i[3];
          mpie_q <= wdata_i[7];
          mpp_q  <= mpp_wr;
        end
        CSR_MIE:    meie_q   <= wdata_i[11];
        CSR_MTVEC:  mtvec_q  <= mtvec_wr;
        CSR_MEPC:   mepc_q   <= {wdata_i[XLEN-1:2], 2'b00};
        CSR_MCAUSE: mcause_q <= wdata_i;
        CSR_MTVAL:  mtval_q  <= wdata_i;
        default: ;
      endcase
    end
  end

  // Combinational read mux; unimplemented addresses read zero
  always_comb begin
    rdata_o = '0;
    case (addr_i)
      CSR_MSTATUS: begin
        rdata_o[3]     = mie_q;
        rdata_o[7]     = mpie_q;
        rdata_o[12:11] = mpp_q;
      end
      CSR_MIE:     rdata_o[11] = meie_q;
      CSR_MTVEC:   rdata_o     = mtvec_q;
      CSR_MEPC:    rdata_o     = mepc_q;
      CSR_MCAUSE:  rdata_o     = mcause_q;
      CSR_MTVAL:   rdata_o     = mtval_q;
      CSR_MIP:     rdata_o[11] = irq_ext_i;
      default:     rdata_o     = '0;
    endcase
  end

  assign mtvec_o = mtvec_q;
  assign mepc_o  = mepc_q;
  assign meie_o  = meie_q;
  assign mie_o   = mie_q;
  assign mpie_o  = mpie_q;
  assign mpp_o   = mpp_q;
  assign priv_o  = priv_q;

endmodule

// File: rtl/trap_handler_ctrl.sv
// rtl/trap_handler_ctrl.sv - machine-mode trap entry/return sequencer and fetch redirect
module trap_handler_ctrl
  import trap_handler_ctrl_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_MTVEC = 32'h0000_0100
) (
  input logic                CLK,
  input logic                RST,
  trap_handler_ctrl_if.slave bus
);

  state_e          state_q, state_d;
  trap_req_t       req_q, req_d;
  logic [XLEN-1:0] target_q, target_d;

  logic            busy;
  logic            flush;
  logic            redirect;
  logic            entry_commit;
  logic            exit_commit;
  logic            csr_we_idle;
  logic            irq_pend;

  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc;
  logic            meie;
  logic            mstatus_mie;
  logic            mstatus_mpie;
  logic [1:0]      mstatus_mpp;
  logic [1:0]      priv;

  // Software CSR writes only land while no trap sequence is in flight
  assign csr_we_idle = bus.csr_we && (state_q == ST_IDLE);
  assign irq_pend    = bus.irq_ext && mstatus_mie && meie;

  trap_csr_file #(
    .XLEN        (XLEN),
    .RESET_MTVEC (RESET_MTVEC)
  ) u_csr (
    .clk_i        (CLK),
    .rst_i        (RST),
    .we_i         (csr_we_idle),
    .addr_i       (bus.csr_addr),
    .wdata_i      (bus.csr_wdata),
    .rdata_o      (bus.csr_rdata),
    .irq_ext_i    (bus.irq_ext),
    .entry_i      (entry_commit),
    .exit_i       (exit_commit),
    .entry_irq_i  (req_q.irq),
    .entry_code_i (req_q.cause),
    .entry_pc_i   (req_q.pc),
    .entry_tval_i (req_q.tval),
    .mtvec_o      (mtvec),
    .mepc_o       (mepc),
    .meie_o       (meie),
    .mie_o        (mstatus_mie),
    .mpie_o       (mstatus_mpie),
    .mpp_o        (mstatus_mpp),
    .priv_o       (priv)
  );

  // Next state, request latch and strobes; the target is resolved from the
  // CSR values seen at the request edge so a coincident CSR write is not used
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    target_d     = target_q;
    busy         = 1'b0;
    flush        = 1'b0;
    redirect     = 1'b0;
    entry_commit = 1'b0;
    exit_commit  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.trap_valid) begin
          state_d     = ST_ENTRY;
          req_d.valid = 1'b1;
          req_d.irq   = 1'b0;
          req_d.cause = bus.trap_cause;
          req_d.pc    = bus.trap_pc;
          req_d.tval  = bus.trap_tval;
          target_d    = trap_target(mtvec, 1'b0, bus.trap_cause);
        end else if (irq_pend) begin
          state_d     = ST_ENTRY;
          req_d.valid = 1'b1;
          req_d.irq   = 1'b1;
          req_d.cause = IRQ_M_EXT;
          req_d.pc    = bus.trap_pc;
          req_d.tval  = '0;
          target_d    = trap_target(mtvec, 1'b1, IRQ_M_EXT);
        end else if (bus.mret_valid) begin
          state_d     = ST_EXIT;
          req_d       = '0;
          target_d    = mepc;
        end
        // Stall the requesting instruction in the accepting cycle as well
        busy = (state_d != ST_IDLE);
      end
      ST_ENTRY: begin
        busy         = 1'b1;
        flush        = 1'b1;
        entry_commit = req_q.valid;
        state_d      = ST_REDIRECT;
      end
      ST_EXIT: begin
        busy        = 1'b1;
        flush       = 1'b1;
        exit_commit = 1'b1;
        state_d     = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        busy     = 1'b1;
        redirect = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer registers; reset abandons any sequence without redirecting
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      req_q    <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      target_q <= target_d;
    end
  end

  assign bus.busy_o           = busy;
  assign bus.flush_o          = flush;
  assign bus.redirect_valid_o = redirect;
  assign bus.redirect_pc_o    = redirect ? target_q : '0;
  assign bus.priv_o           = priv;
  assign bus.mie_o            = mstatus_mie;
  assign bus.mpie_o           = mstatus_mpie;
  assign bus.mpp_o            = mstatus_mpp;

endmodule
